// File: rtl/read_return_mux.sv
// Read-return multiplexer: forwards one read from the addressed target back to the master.
// Optional macro RETURN_TIMEOUT_EN adds a 15-cycle WAIT timeout that returns 4'hF with ERR=1.
module read_return_mux (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       REQ,
    input  logic [2:0] ADDR,
    input  logic [3:0] DATA0,
    input  logic       READY0,
    input  logic [3:0] DATA1,
    input  logic       READY1,
    input  logic       RACK,
    output logic       BUSY,
    output logic [3:0] RDATA,
    output logic       RVALID,
    output logic       ERR
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state_reg;
    logic       sel_reg;
    logic [3:0] rdata_reg;
    logic       sel_ready;
    logic [3:0] sel_data;

    // Only the latched target is looked at; the other READY never matters.
    assign sel_ready = sel_reg ? READY1 : READY0;
    assign sel_data  = sel_reg ? DATA1  : DATA0;

`ifdef RETURN_TIMEOUT_EN
    logic [3:0] cnt_reg;
    logic       err_reg;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
            rdata_reg <= 4'h0;
            err_reg   <= 1'b0;
            cnt_reg   <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (REQ) begin
                        sel_reg   <= (ADDR != 3'b001);
                        cnt_reg   <= 4'd0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (sel_ready) begin
                        rdata_reg <= sel_data;
                        err_reg   <= 1'b0;
                        state_reg <= RESP;
                    end else if (cnt_reg == 4'd14) begin
                        // 15th consecutive cycle without data: return an error response
                        rdata_reg <= 4'hF;
                        err_reg   <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                RESP: begin
                    if (RACK) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ERR = err_reg;
`else
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
            rdata_reg <= 4'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (REQ) begin
                        sel_reg   <= (ADDR != 3'b001);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (sel_ready) begin
                        rdata_reg <= sel_data;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (RACK) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ERR = 1'b0;
`endif

    // Status decodes straight from the state register so reset clears them at once.
    assign BUSY   = (state_reg != IDLE);
    assign RVALID = (state_reg == RESP);
    assign RDATA  = rdata_reg;

endmodule

// File: tb/tb_read_return_mux.sv
// Directed bench for read_return_mux: a transaction-level model checked every cycle,
// plus literal expectations at key points. Honors RETURN_TIMEOUT_EN like the design.
module tb_read_return_mux;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       REQ = 1'b0;
    logic [2:0] ADDR = 3'b000;
    logic [3:0] DATA0 = 4'h0;
    logic       READY0 = 1'b0;
    logic [3:0] DATA1 = 4'h0;
    logic       READY1 = 1'b0;
    logic       RACK = 1'b0;
    logic       BUSY;
    logic [3:0] RDATA;
    logic       RVALID;
    logic       ERR;

    int n_tests = 0;
    int n_fail  = 0;

    read_return_mux dut (
        .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .ADDR(ADDR),
        .DATA0(DATA0), .READY0(READY0), .DATA1(DATA1), .READY1(READY1),
        .RACK(RACK), .BUSY(BUSY), .RDATA(RDATA), .RVALID(RVALID), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

`ifdef RETURN_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    // Transaction model: a pending read is either waiting or answered.
    bit       m_pending = 1'b0;
    bit       m_answered = 1'b0;
    bit       m_target = 1'b0;
    int       m_waited = 0;
    bit [3:0] m_rdata = 4'h0;
    bit       m_err = 1'b0;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_pending = 1'b0; m_answered = 1'b0; m_target = 1'b0;
            m_waited = 0; m_rdata = 4'h0; m_err = 1'b0;
        end else if (!m_pending) begin
            if (REQ) begin
                m_pending = 1'b1;
                m_target  = (ADDR == 3'b001) ? 1'b0 : 1'b1;
                m_waited  = 0;
            end
        end else if (!m_answered) begin
            if ((m_target == 1'b0 && READY0) || (m_target == 1'b1 && READY1)) begin
                m_answered = 1'b1;
                m_rdata = m_target ? DATA1 : DATA0;
                m_err = 1'b0;
            end else begin
                m_waited++;
                if (TMO && m_waited == 15) begin
                    m_answered = 1'b1;
                    m_rdata = 4'hF;
                    m_err = 1'b1;
                end
            end
        end else if (RACK) begin
            m_pending = 1'b0;
            m_answered = 1'b0;
        end
    end

    task automatic cmp(string name, logic [3:0] act, logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare on the inactive edge.
    always @(negedge CLK) begin
        cmp("model_busy",   {3'b0, BUSY},   {3'b0, m_pending});
        cmp("model_rvalid", {3'b0, RVALID}, {3'b0, m_answered});
        cmp("model_rdata",  RDATA,          m_rdata);
        cmp("model_err",    {3'b0, ERR},    {3'b0, m_answered & m_err});
    end

    task automatic cyc(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic lit(string name, logic b, logic v, logic [3:0] d, logic e,
                       logic eb, logic ev, logic [3:0] ed, logic ee);
        cmp({name, "_busy"},   {3'b0, b}, {3'b0, eb});
        cmp({name, "_rvalid"}, {3'b0, v}, {3'b0, ev});
        cmp({name, "_rdata"},  d, ed);
        cmp({name, "_err"},    {3'b0, e}, {3'b0, ee});
    endtask

    initial begin
        #2;
        lit("reset", BUSY, RVALID, RDATA, ERR, 1'b0, 1'b0, 4'h0, 1'b0);
        cyc(2);
        RESETN = 1'b1;

        // 1: target 0 immediate data, held three cycles, then acknowledged
        REQ = 1'b1; ADDR = 3'b001;
        cyc(1);
        REQ = 1'b0; READY0 = 1'b1; DATA0 = 4'hA;
        lit("s1_wait", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b0, 4'h0, 1'b0);
        cyc(1);
        READY0 = 1'b0; DATA0 = 4'h1;
        lit("s1_resp", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b1, 4'hA, 1'b0);
        cyc(3);
        lit("s1_hold", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b1, 4'hA, 1'b0);
        RACK = 1'b1;
        cyc(1);
        RACK = 1'b0;
        lit("s1_idle", BUSY, RVALID, RDATA, ERR, 1'b0, 1'b0, 4'hA, 1'b0);

        // 2: default mapping to target 1, READY0 ignored
        REQ = 1'b1; ADDR = 3'b111;
        cyc(1);
        REQ = 1'b0; READY0 = 1'b1; DATA0 = 4'h3;
        cyc(2);
        lit("s2_ign", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b0, 4'hA, 1'b0);
        READY0 = 1'b0; READY1 = 1'b1; DATA1 = 4'h6;
        cyc(1);
        READY1 = 1'b0;
        lit("s2_resp", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b1, 4'h6, 1'b0);
        RACK = 1'b1; cyc(1); RACK = 1'b0;

        // 3: REQ during WAIT does not reselect or start a second read
        REQ = 1'b1; ADDR = 3'b010;
        cyc(1);
        ADDR = 3'b001; READY0 = 1'b1; DATA0 = 4'h5;
        cyc(1);
        REQ = 1'b0; READY0 = 1'b0;
        lit("s3_wait", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b0, 4'h6, 1'b0);
        READY1 = 1'b1; DATA1 = 4'h9;
        cyc(1);
        READY1 = 1'b0;
        lit("s3_resp", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b1, 4'h9, 1'b0);
        RACK = 1'b1; cyc(1); RACK = 1'b0;
        cyc(2);
        lit("s3_idle", BUSY, RVALID, RDATA, ERR, 1'b0, 1'b0, 4'h9, 1'b0);

        // 4: target 1 never ready
        REQ = 1'b1; ADDR = 3'b010;
        cyc(1);
        REQ = 1'b0;
`ifdef RETURN_TIMEOUT_EN
        cyc(14);
        lit("s4_pre", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b0, 4'h9, 1'b0);
        cyc(1);
        lit("s4_tmo", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b1, 4'hF, 1'b1);
        RACK = 1'b1; cyc(1); RACK = 1'b0;
        // data arriving on the timeout edge wins
        REQ = 1'b1; ADDR = 3'b010;
        cyc(1);
        REQ = 1'b0;
        cyc(14);
        READY1 = 1'b1; DATA1 = 4'h7;
        cyc(1);
        READY1 = 1'b0;
        lit("s4_race", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b1, 4'h7, 1'b0);
`else
        cyc(40);
        lit("s4_stall", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b0, 4'h9, 1'b0);
        READY1 = 1'b1; DATA1 = 4'h2;
        cyc(1);
        READY1 = 1'b0;
        lit("s4_late", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b1, 4'h2, 1'b0);
`endif
        RACK = 1'b1; cyc(1); RACK = 1'b0;

        // 5: half-cycle reset pulse in RESP aborts immediately
        REQ = 1'b1; ADDR = 3'b001;
        cyc(1);
        REQ = 1'b0; READY0 = 1'b1; DATA0 = 4'hC;
        cyc(1);
        READY0 = 1'b0;
        lit("s5_resp", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b1, 4'hC, 1'b0);
        #1 RESETN = 1'b0;
        #1 lit("s5_rst", BUSY, RVALID, RDATA, ERR, 1'b0, 1'b0, 4'h0, 1'b0);
        #3 RESETN = 1'b1;
        cyc(1);
        REQ = 1'b1; ADDR = 3'b010;
        cyc(1);
        REQ = 1'b0; READY1 = 1'b1; DATA1 = 4'h4;
        cyc(1);
        READY1 = 1'b0;
        lit("s5_new", BUSY, RVALID, RDATA, ERR, 1'b1, 1'b1, 4'h4, 1'b0);
        RACK = 1'b1; cyc(1); RACK = 1'b0;

        // 6: REQ coinciding with RACK is dropped
        REQ = 1'b1; ADDR = 3'b001;
        cyc(1);
        REQ = 1'b0; READY0 = 1'b1; DATA0 = 4'h8;
        cyc(1);
        READY0 = 1'b0;
        RACK = 1'b1; REQ = 1'b1;
        cyc(1);
        RACK = 1'b0; REQ = 1'b0;
        lit("s6_idle", BUSY, RVALID, RDATA, ERR, 1'b0, 1'b0, 4'h8, 1'b0);
        cyc(2);
        lit("s6_stay", BUSY, RVALID, RDATA, ERR, 1'b0, 1'b0, 4'h8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
